// File: rtl/chargen_pkg.sv
// Shared types and constants for the chargen_src character generator.
//   ASCII_CR / ASCII_LF : line terminator bytes
//   state_e             : generator FSM states
//   offset_t            : 7-bit character offset within the rotating set
//   mod_step            : one compare/subtract stage of a mod-N reduction
package chargen_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHAR,
    S_CR,
    S_LF
  } state_e;

  typedef logic [6:0] offset_t;

  // Subtract the modulus once if the value is at or above it.
  function automatic logic [8:0] mod_step(input logic [8:0] val, input logic [8:0] modulus);
    return (val >= modulus) ? (val - modulus) : val;
  endfunction

endpackage

// File: rtl/chargen_mod_ctr.sv
// Modulo-N up-counter with synchronous active-high reset.
//   clk_i      : clock
//   rst_i      : synchronous reset, clears count to 0
//   inc_i      : advance by one this cycle
//   cnt_nxt_o  : value the counter will hold after this edge
//   wrap_o     : high when inc_i is set at Modulus-1 (count returns to 0)
module chargen_mod_ctr #(
  parameter int unsigned Modulus = 2,
  parameter int unsigned Width   = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_nxt_o,
  output logic             wrap_o
);

  localparam logic [Width-1:0] CntMax = Width'(Modulus - 1);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    wrap_o = 1'b0;
    if (inc_i) begin
      if (cnt_q == CntMax) begin
        cnt_d  = '0;
        wrap_o = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign cnt_nxt_o = cnt_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/chargen_src.sv
// RFC 864-style character generator feeding a byte consumer over an
// active-low valid/ready handshake. Emits rotating lines of printable ASCII,
// each line starting one character later than the previous one.
//   clk_i       : clock, rising edge
//   rst_i       : synchronous active-high reset
//   en_i        : run enable, only sampled when no byte is pending
//   ready_n_i   : consumer ready (active low)
//   valid_n_o   : byte valid (active low)
//   data_o      : presented byte
//   line_done_o : one-cycle pulse after the final terminator byte transfers
// Build option: define CHARGEN_CR_EN for a CR LF terminator; otherwise LF only.
module chargen_src
  import chargen_pkg::*;
#(
  parameter int unsigned LINE_LEN = 72,
  parameter logic [7:0]  FIRST    = 8'h20,
  parameter logic [7:0]  LAST     = 8'h7E
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       ready_n_i,
  output logic       valid_n_o,
  output logic [7:0] data_o,
  output logic       line_done_o
);

  localparam int unsigned N = int'(LAST) - int'(FIRST) + 1;
  // Enough compare/subtract stages to reduce line_start + col below N.
  localparam int unsigned RedSteps = (LINE_LEN - 1) / N + 1;

  state_e     state_q, state_d;
  logic [7:0] data_q, data_d;
  logic       line_done_q, line_done_d;

  logic       xfer;
  logic       col_inc, col_wrap;
  logic       ls_inc, unused_ls_wrap;
  logic [7:0] col_nxt;
  offset_t    ls_nxt;
  logic [8:0] pos_sum;
  logic [7:0] char_nxt;

  chargen_mod_ctr #(
    .Modulus(LINE_LEN),
    .Width  (8)
  ) u_col_ctr (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .inc_i    (col_inc),
    .cnt_nxt_o(col_nxt),
    .wrap_o   (col_wrap)
  );

  chargen_mod_ctr #(
    .Modulus(N),
    .Width  ($bits(offset_t))
  ) u_ls_ctr (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .inc_i    (ls_inc),
    .cnt_nxt_o(ls_nxt),
    .wrap_o   (unused_ls_wrap)
  );

  assign xfer = (state_q != S_IDLE) && !ready_n_i;

  // Character at the position the counters hold after this edge, so a byte
  // loaded on a transfer edge is already the following one.
  always_comb begin
    pos_sum = {2'b00, ls_nxt} + {1'b0, col_nxt};
    for (int unsigned i = 0; i < RedSteps; i++) begin
      pos_sum = mod_step(pos_sum, 9'(N));
    end
    char_nxt = FIRST + pos_sum[7:0];
  end

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    line_done_d = 1'b0;
    col_inc     = 1'b0;
    ls_inc      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en_i) begin
          state_d = S_CHAR;
          data_d  = char_nxt;
        end
      end
      S_CHAR: begin
        if (xfer) begin
          col_inc = 1'b1;
          if (col_wrap) begin
`ifdef CHARGEN_CR_EN
            state_d = S_CR;
            data_d  = ASCII_CR;
`else
            state_d = S_LF;
            data_d  = ASCII_LF;
`endif
          end else if (en_i) begin
            data_d = char_nxt;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
`ifdef CHARGEN_CR_EN
      S_CR: begin
        if (xfer) begin
          state_d = S_LF;
          data_d  = ASCII_LF;
        end
      end
`endif
      S_LF: begin
        if (xfer) begin
          // col already wrapped to 0 on the last character transfer.
          ls_inc      = 1'b1;
          line_done_d = 1'b1;
          if (en_i) begin
            state_d = S_CHAR;
            data_d  = char_nxt;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      data_q      <= FIRST;
      line_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      line_done_q <= line_done_d;
    end
  end

  assign valid_n_o   = (state_q == S_IDLE);
  assign data_o      = data_q;
  assign line_done_o = line_done_q;

endmodule

// File: tb/tb_chargen_src.sv
// Directed self-checking bench for chargen_src (default geometry: 72 chars,
// 0x20..0x7E). Follows the CHARGEN_CR_EN build option for the terminator.
module tb_chargen_src;

  localparam int LineLen = 72;

  logic       clk;
  logic       rst;
  logic       en;
  logic       ready_n;
  logic       valid_n;
  logic [7:0] data;
  logic       line_done;

  int n_tests;
  int n_fail;
  int ld_cnt;

  chargen_src u_dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en),
    .ready_n_i  (ready_n),
    .valid_n_o  (valid_n),
    .data_o     (data),
    .line_done_o(line_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (line_done === 1'b1) ld_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expect a presented byte, then let it transfer (ready_n assumed low).
  task automatic take(input logic [7:0] exp, input string tag);
    check({tag, "_valid_n"}, {31'b0, valid_n}, 32'd0);
    check({tag, "_data"}, {24'b0, data}, {24'b0, exp});
    step();
  endtask

  function automatic logic [7:0] model_char(input int line, input int col);
    return 8'(32'h20 + ((line % 95) + col) % 95);
  endfunction

  // Consume one whole line at full rate; returns mismatch count and first two bytes.
  task automatic run_line(input int line, output int errs, output logic [7:0] b0,
                          output logic [7:0] b1);
    errs = 0;
    b0   = 8'h00;
    b1   = 8'h00;
    for (int c = 0; c < LineLen; c++) begin
      if (c == 0) b0 = data;
      if (c == 1) b1 = data;
      if (valid_n !== 1'b0 || data !== model_char(line, c)) errs++;
      step();
    end
`ifdef CHARGEN_CR_EN
    if (valid_n !== 1'b0 || data !== 8'h0D) errs++;
    step();
`endif
    if (valid_n !== 1'b0 || data !== 8'h0A) errs++;
    step();
    if (line_done !== 1'b1) errs++;
  endtask

  initial begin
    int         errs;
    int         tot;
    int         ld_before;
    logic [7:0] b0, b1;

    n_tests = 0;
    n_fail  = 0;
    ld_cnt  = 0;
    rst     = 1'b1;
    en      = 1'b0;
    ready_n = 1'b0;

    // Reset and start-up latency.
    step();
    step();
    check("rst_valid_n", {31'b0, valid_n}, 32'd1);
    check("rst_data", {24'b0, data}, 32'h20);
    check("rst_line_done", {31'b0, line_done}, 32'd0);
    rst = 1'b0;
    step();
    check("idle_en0_valid_n", {31'b0, valid_n}, 32'd1);
    en = 1'b1;
    step();
    check("start_valid_n", {31'b0, valid_n}, 32'd0);
    check("start_data", {24'b0, data}, 32'h20);

    // Line 0 byte by byte at full rate.
    ld_before = ld_cnt;
    for (int c = 0; c < LineLen; c++) take(8'(32'h20 + c), "line0_char");
`ifdef CHARGEN_CR_EN
    take(8'h0D, "line0_cr");
`endif
    take(8'h0A, "line0_lf");
    check("line0_done", {31'b0, line_done}, 32'd1);
    check("line1_first_valid_n", {31'b0, valid_n}, 32'd0);
    check("line1_first_data", {24'b0, data}, 32'h21);
    step();
    check("line0_done_once", ld_cnt - ld_before, 32'd1);

    // Line 1 already advanced one byte; finish it by hand then lines 2..93.
    tot = 0;
    for (int c = 1; c < LineLen; c++) begin
      if (valid_n !== 1'b0 || data !== model_char(1, c)) tot++;
      step();
    end
`ifdef CHARGEN_CR_EN
    if (data !== 8'h0D) tot++;
    step();
`endif
    if (data !== 8'h0A) tot++;
    step();
    for (int ln = 2; ln < 94; ln++) begin
      run_line(ln, errs, b0, b1);
      tot += errs;
    end
    check("lines_1_93_errs", tot, 32'd0);

    // Wrap of the rotating set.
    check("line94_first", {24'b0, data}, 32'h7E);
    run_line(94, errs, b0, b1);
    check("line94_errs", errs, 32'd0);
    check("line94_second", {24'b0, b1}, 32'h20);
    check("line95_first", {24'b0, data}, 32'h20);

    // Enable drop with 0x25 pending.
    for (int c = 0; c < 5; c++) take(8'(32'h20 + c), "line95_head");
    check("endrop_pending", {24'b0, data}, 32'h25);
    en = 1'b0;
    step();
    check("endrop_idle", {31'b0, valid_n}, 32'd1);
    step();
    step();
    check("endrop_stay_idle", {31'b0, valid_n}, 32'd1);
    en = 1'b1;
    step();
    check("resume_valid_n", {31'b0, valid_n}, 32'd0);
    check("resume_data", {24'b0, data}, 32'h26);

    // Backpressure on 0x26.
    ready_n = 1'b1;
    errs    = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (valid_n !== 1'b0 || data !== 8'h26) errs++;
    end
    check("bp_hold_errs", errs, 32'd0);
    ready_n = 1'b0;
    step();
    check("bp_release_next", {24'b0, data}, 32'h27);
    check("bp_release_valid_n", {31'b0, valid_n}, 32'd0);

    // Advance to column 40, then reset with the byte pending.
    errs = 0;
    for (int c = 7; c < 40; c++) begin
      if (valid_n !== 1'b0 || data !== model_char(95, c)) errs++;
      step();
    end
    check("to_col40_errs", errs, 32'd0);
    check("col40_data", {24'b0, data}, 32'h48);
    rst = 1'b1;
    step();
    check("midrst_valid_n", {31'b0, valid_n}, 32'd1);
    check("midrst_data", {24'b0, data}, 32'h20);
    rst = 1'b0;
    step();
    check("postrst_valid_n", {31'b0, valid_n}, 32'd0);
    check("postrst_data", {24'b0, data}, 32'h20);
    step();
    check("postrst_second", {24'b0, data}, 32'h21);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
